// File: rtl/interrupt_controller_if.sv
// Register bus between the CPU memory map and the interrupt controller (IF/IE access).
interface interrupt_controller_if;
  logic [15:0] i_Addr;
  logic [7:0]  i_Data;
  logic        i_Write;
  logic [7:0]  o_Data;

  modport master (output i_Addr, output i_Data, output i_Write, input  o_Data);
  modport slave  (input  i_Addr, input  i_Data, input  i_Write, output o_Data);
endinterface

// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF edge capture, IE, IME sequencing and vector dispatch.
// Define INTC_EI_DELAY_EN to delay IME by one instruction after EI (ARM1/ARM2 path).
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic                  i_Clk,
  input  logic                  i_nRst,
  input  logic                  i_Enable,
  input  logic [4:0]            i_Irq_Sources,
  interrupt_controller_if.slave bus,
  output logic [4:0]            o_Interrupts,
  output logic                  o_Irq_Request,
  input  logic                  i_Ack,
  output logic [7:0]            o_Vector,
  output logic                  o_Vector_Valid,
  input  logic                  i_EI,
  input  logic                  i_DI,
  input  logic                  i_RETI,
  input  logic                  i_Instr_Boundary
);
  typedef enum logic [1:0] {IDLE_OFF, ARM1, ARM2, ON} ime_state_e;

  ime_state_e ime_q, ime_d;
  logic [4:0] prev_q, prev_d, if_q, if_d;
  logic [7:0] ie_q, ie_d, vector_q, vector_d;
  logic       vld_q, vld_d;

  logic [4:0] pending, edges, ack_clear;
  logic [7:0] win_vec;
  logic       ack, wr_if, wr_ie;

  assign pending = if_q & ie_q[4:0];
  assign edges   = i_Irq_Sources & ~prev_q;
  assign ack     = i_Ack & i_Enable;
  assign wr_if   = bus.i_Write & (bus.i_Addr == IF_ADDR);
  assign wr_ie   = bus.i_Write & (bus.i_Addr == IE_ADDR);

  // x & -x isolates the lowest set bit, i.e. the highest-priority request
  assign ack_clear = ack ? (pending & (~pending + 5'd1)) : 5'd0;

  always_comb begin
    win_vec = 8'h00;
    for (int i = 4; i >= 0; i--)
      if (pending[i]) win_vec = 8'h40 + 8'(8 * i);
  end

  always_comb begin
    prev_d   = prev_q;
    if_d     = if_q;
    ie_d     = ie_q;
    vector_d = vector_q;
    vld_d    = ack;
    if (i_Enable) begin
      prev_d = i_Irq_Sources;
      // write first, then ack clear, and a fresh edge always survives both
      if_d   = ((wr_if ? bus.i_Data[4:0] : if_q) & ~ack_clear) | edges;
      if (wr_ie) ie_d = bus.i_Data;
      if (ack) vector_d = win_vec;
    end
  end

  always_comb begin
    ime_d = ime_q;
    if (i_Enable) begin
      if (i_DI || i_Ack) ime_d = IDLE_OFF;
      else if (i_RETI)   ime_d = ON;
      else begin
        case (ime_q)
          IDLE_OFF: if (i_EI) begin
`ifdef INTC_EI_DELAY_EN
            ime_d = ARM1;
`else
            ime_d = ON;
`endif
          end
          ARM1:     if (i_Instr_Boundary) ime_d = ARM2;
          ARM2:     if (i_Instr_Boundary) ime_d = ON;
          default:  ime_d = ime_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      ime_q    <= IDLE_OFF;
      prev_q   <= '0;
      if_q     <= '0;
      ie_q     <= '0;
      vector_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      ime_q    <= ime_d;
      prev_q   <= prev_d;
      if_q     <= if_d;
      ie_q     <= ie_d;
      vector_q <= vector_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.o_Data     = (bus.i_Addr == IF_ADDR) ? {3'b111, if_q} :
                          (bus.i_Addr == IE_ADDR) ? ie_q : 8'h00;
  assign o_Interrupts   = pending;
  assign o_Irq_Request  = (ime_q == ON) & (|pending);
  assign o_Vector       = vector_q;
  assign o_Vector_Valid = vld_q & i_Enable;
endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a behavioural model.
module tb_interrupt_controller;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;
`ifdef INTC_EI_DELAY_EN
  localparam int EI_DLY = 2;
`else
  localparam int EI_DLY = 0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_nRst = 1'b0;
  logic       i_Enable = 1'b0;
  logic [4:0] i_Irq_Sources = '0;
  logic       i_Ack = 0, i_EI = 0, i_DI = 0, i_RETI = 0, i_Instr_Boundary = 0;
  logic [4:0] o_Interrupts;
  logic       o_Irq_Request;
  logic [7:0] o_Vector;
  logic       o_Vector_Valid;

  interrupt_controller_if bus();

  interrupt_controller #(.IF_ADDR(IF_ADDR), .IE_ADDR(IE_ADDR)) dut (
    .i_Clk(i_Clk), .i_nRst(i_nRst), .i_Enable(i_Enable), .i_Irq_Sources(i_Irq_Sources),
    .bus(bus.slave), .o_Interrupts(o_Interrupts), .o_Irq_Request(o_Irq_Request),
    .i_Ack(i_Ack), .o_Vector(o_Vector), .o_Vector_Valid(o_Vector_Valid),
    .i_EI(i_EI), .i_DI(i_DI), .i_RETI(i_RETI), .i_Instr_Boundary(i_Instr_Boundary)
  );

  always #5 i_Clk = ~i_Clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: IME is a flag plus a count of boundaries still owed after EI.
  logic [4:0] m_prev, m_if;
  logic [7:0] m_ie, m_vec;
  bit         m_ime, m_vld;
  int         m_arm;

  function automatic void model_reset();
    m_prev = '0; m_if = '0; m_ie = '0; m_vec = '0; m_ime = 0; m_vld = 0; m_arm = 0;
  endfunction

  function automatic logic [7:0] m_read(logic [15:0] a);
    if (a == IF_ADDR) return {3'b111, m_if};
    if (a == IE_ADDR) return m_ie;
    return 8'h00;
  endfunction

  function automatic void model_step();
    logic [4:0] e, p, clr, base;
    if (!i_nRst) begin model_reset(); return; end
    m_vld = 0;
    if (!i_Enable) return;
    e = i_Irq_Sources & ~m_prev;
    m_prev = i_Irq_Sources;
    p = m_if & m_ie[4:0];
    clr = '0;
    if (i_Ack) begin
      m_vld = 1;
      m_vec = 8'h00;
      for (int n = 0; n < 5; n++)
        if (p[n]) begin clr = 5'(1 << n); m_vec = 8'h40 + 8'(8 * n); break; end
    end
    base = (bus.i_Write && bus.i_Addr == IF_ADDR) ? bus.i_Data[4:0] : m_if;
    m_if = (base & ~clr) | e;
    if (bus.i_Write && bus.i_Addr == IE_ADDR) m_ie = bus.i_Data;
    if (i_DI || i_Ack) begin m_ime = 0; m_arm = 0; end
    else if (i_RETI) begin m_ime = 1; m_arm = 0; end
    else if (m_arm > 0) begin
      if (i_Instr_Boundary) begin m_arm--; if (m_arm == 0) m_ime = 1; end
    end else if (i_EI && !m_ime) begin
      if (EI_DLY == 0) m_ime = 1; else m_arm = EI_DLY;
    end
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    i_Ack = 0; i_EI = 0; i_DI = 0; i_RETI = 0; i_Instr_Boundary = 0;
    bus.i_Write = 0; bus.i_Addr = IF_ADDR; bus.i_Data = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.i_Write = 1; bus.i_Addr = a; bus.i_Data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    i_Irq_Sources = 5'b00001;
    tick(); tick();
    vectors++; if (o_Interrupts !== 5'b0) begin errors++; $display("FAIL reset_ints got %b exp 00000", o_Interrupts); end
    vectors++; if (o_Irq_Request !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", o_Irq_Request); end
    vectors++; if (o_Vector !== 8'h00 || o_Vector_Valid !== 1'b0) begin errors++; $display("FAIL reset_vec got %h/%b exp 00/0", o_Vector, o_Vector_Valid); end
    vectors++; if (bus.o_Data !== 8'hE0) begin errors++; $display("FAIL reset_if_read got %h exp e0", bus.o_Data); end
    bus.i_Addr = 16'h0000; #1;
    vectors++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL nomatch_read got %h exp 00", bus.o_Data); end
    bus.i_Addr = IE_ADDR; #1;
    vectors++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL reset_ie_read got %h exp 00", bus.o_Data); end
    // line already high when reset releases must register as an edge
    i_nRst = 1; i_Enable = 1; bus.i_Addr = IF_ADDR;
    tick();
    vectors++; if (bus.o_Data !== 8'hE1) begin errors++; $display("FAIL release_edge got %h exp e1", bus.o_Data); end
    wr(IF_ADDR, 8'h00);
    i_Irq_Sources = '0;
    tick();
  endtask

  task automatic test_if_edge();
    wr(IE_ADDR, 8'h1F);
    i_Irq_Sources = 5'b00100;
    tick();
    i_Irq_Sources = '0;
    vectors++; if (bus.o_Data !== 8'hE4) begin errors++; $display("FAIL edge_if got %h exp e4", bus.o_Data); end
    vectors++; if (o_Interrupts !== 5'b00100) begin errors++; $display("FAIL edge_ints got %b exp 00100", o_Interrupts); end
    vectors++; if (o_Irq_Request !== 1'b0) begin errors++; $display("FAIL edge_irq_imeoff got %b exp 0", o_Irq_Request); end
  endtask

  task automatic test_ei_delay();
    i_EI = 1; tick(); i_EI = 0;
    vectors++; if (o_Irq_Request !== (EI_DLY == 0)) begin errors++; $display("FAIL ei_step0 got %b exp %b", o_Irq_Request, EI_DLY == 0); end
    i_Instr_Boundary = 1; tick(); i_Instr_Boundary = 0;
    vectors++; if (o_Irq_Request !== (EI_DLY == 0)) begin errors++; $display("FAIL ei_bnd1 got %b exp %b", o_Irq_Request, EI_DLY == 0); end
    i_Instr_Boundary = 1; tick(); i_Instr_Boundary = 0;
    vectors++; if (o_Irq_Request !== 1'b1) begin errors++; $display("FAIL ei_bnd2 got %b exp 1", o_Irq_Request); end
    i_DI = 1; tick(); i_DI = 0;
    vectors++; if (o_Irq_Request !== 1'b0) begin errors++; $display("FAIL di_off got %b exp 0", o_Irq_Request); end
  endtask

  task automatic test_ack();
    wr(IF_ADDR, 8'h16);
    i_RETI = 1; tick(); i_RETI = 0;
    vectors++; if (o_Irq_Request !== 1'b1) begin errors++; $display("FAIL reti_on got %b exp 1", o_Irq_Request); end
    i_Ack = 1; tick(); i_Ack = 0;
    vectors++; if (o_Vector !== 8'h48 || o_Vector_Valid !== 1'b1) begin errors++; $display("FAIL ack_vec got %h/%b exp 48/1", o_Vector, o_Vector_Valid); end
    vectors++; if (bus.o_Data !== 8'hF4) begin errors++; $display("FAIL ack_if got %h exp f4", bus.o_Data); end
    vectors++; if (o_Irq_Request !== 1'b0) begin errors++; $display("FAIL ack_ime got %b exp 0", o_Irq_Request); end
    tick();
    vectors++; if (o_Vector_Valid !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b exp 0", o_Vector_Valid); end
  endtask

  task automatic test_ack_empty();
    i_RETI = 1; tick(); i_RETI = 0;
    wr(IE_ADDR, 8'h00);
    i_Ack = 1; tick(); i_Ack = 0;
    vectors++; if (o_Vector !== 8'h00 || o_Vector_Valid !== 1'b1) begin errors++; $display("FAIL empty_vec got %h/%b exp 00/1", o_Vector, o_Vector_Valid); end
    vectors++; if (bus.o_Data !== 8'hF4) begin errors++; $display("FAIL empty_if got %h exp f4", bus.o_Data); end
    wr(IE_ADDR, 8'h1F);
    vectors++; if (o_Interrupts !== 5'b10100 || o_Irq_Request !== 1'b0) begin errors++; $display("FAIL empty_ime got %b/%b exp 10100/0", o_Interrupts, o_Irq_Request); end
  endtask

  task automatic test_write_edge();
    i_Irq_Sources = 5'b00001;
    wr(IF_ADDR, 8'h00);
    i_Irq_Sources = '0;
    vectors++; if (bus.o_Data !== 8'hE1) begin errors++; $display("FAIL wr_edge got %h exp e1", bus.o_Data); end
  endtask

  task automatic test_di_ei_reti();
    i_DI = 1; i_EI = 1; tick(); i_DI = 0; i_EI = 0;
    repeat (2) begin i_Instr_Boundary = 1; tick(); i_Instr_Boundary = 0; end
    vectors++; if (o_Irq_Request !== 1'b0) begin errors++; $display("FAIL di_ei got %b exp 0", o_Irq_Request); end
    i_RETI = 1; tick(); i_RETI = 0;
    vectors++; if (o_Irq_Request !== 1'b1) begin errors++; $display("FAIL reti got %b exp 1", o_Irq_Request); end
  endtask

  task automatic test_enable_low();
    i_Enable = 0; i_Ack = 1; i_DI = 1; i_Irq_Sources = 5'b01000;
    bus.i_Write = 1; bus.i_Addr = IE_ADDR; bus.i_Data = 8'h00;
    tick();
    idle(); i_Irq_Sources = '0;
    vectors++; if (o_Irq_Request !== 1'b1 || o_Interrupts !== 5'b00001) begin errors++; $display("FAIL dis_hold got %b/%b exp 1/00001", o_Irq_Request, o_Interrupts); end
    vectors++; if (o_Vector !== 8'h00 || o_Vector_Valid !== 1'b0) begin errors++; $display("FAIL dis_vec got %h/%b exp 00/0", o_Vector, o_Vector_Valid); end
    i_Enable = 1;
    i_Ack = 1; tick(); i_Ack = 0;
    vectors++; if (o_Vector !== 8'h40 || o_Vector_Valid !== 1'b1) begin errors++; $display("FAIL en_ack got %h/%b exp 40/1", o_Vector, o_Vector_Valid); end
    i_Enable = 0; #1;
    vectors++; if (o_Vector_Valid !== 1'b0 || o_Vector !== 8'h40) begin errors++; $display("FAIL dis_force got %h/%b exp 40/0", o_Vector, o_Vector_Valid); end
    i_Enable = 1;
  endtask

  task automatic test_random();
    logic [15:0] addrs [4];
    addrs = '{IF_ADDR, IE_ADDR, 16'hFF00, 16'h1234};
    for (int c = 0; c < 400; c++) begin
      i_Enable         = ($urandom_range(0, 9) != 0);
      i_Irq_Sources    = i_Irq_Sources ^ (5'($urandom) & 5'($urandom));
      i_Ack            = ($urandom_range(0, 7) == 0);
      i_EI             = ($urandom_range(0, 9) == 0);
      i_DI             = ($urandom_range(0, 19) == 0);
      i_RETI           = ($urandom_range(0, 24) == 0);
      i_Instr_Boundary = ($urandom_range(0, 2) == 0);
      bus.i_Write      = ($urandom_range(0, 5) == 0);
      bus.i_Addr       = addrs[$urandom_range(0, 3)];
      bus.i_Data       = 8'($urandom);
      tick();
      vectors++; if (bus.o_Data !== m_read(bus.i_Addr)) begin errors++; $display("FAIL rnd_read c=%0d got %h exp %h", c, bus.o_Data, m_read(bus.i_Addr)); end
      vectors++; if (o_Interrupts !== (m_if & m_ie[4:0])) begin errors++; $display("FAIL rnd_ints c=%0d got %b exp %b", c, o_Interrupts, m_if & m_ie[4:0]); end
      vectors++; if (o_Irq_Request !== (m_ime && |(m_if & m_ie[4:0]))) begin errors++; $display("FAIL rnd_irq c=%0d got %b exp %b", c, o_Irq_Request, m_ime && |(m_if & m_ie[4:0])); end
      vectors++; if (o_Vector !== m_vec) begin errors++; $display("FAIL rnd_vec c=%0d got %h exp %h", c, o_Vector, m_vec); end
      vectors++; if (o_Vector_Valid !== (m_vld & i_Enable)) begin errors++; $display("FAIL rnd_vld c=%0d got %b exp %b", c, o_Vector_Valid, m_vld & i_Enable); end
    end
    idle(); i_Enable = 1; i_Irq_Sources = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    wr(IE_ADDR, 8'h1F);
    wr(IF_ADDR, 8'h1F);
    i_RETI = 1; tick(); i_RETI = 0;
    vectors++; if (o_Irq_Request !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got %b exp 1", o_Irq_Request); end
    i_Ack = 1; #2;
    i_nRst = 0; model_reset(); #1;
    vectors++; if (o_Interrupts !== 5'b0 || o_Irq_Request !== 1'b0) begin errors++; $display("FAIL async_rst got %b/%b exp 00000/0", o_Interrupts, o_Irq_Request); end
    vectors++; if (bus.o_Data !== 8'hE0) begin errors++; $display("FAIL async_rst_if got %h exp e0", bus.o_Data); end
    tick();
    i_Ack = 0;
    vectors++; if (o_Vector !== 8'h00 || o_Vector_Valid !== 1'b0) begin errors++; $display("FAIL lost_ack got %h/%b exp 00/0", o_Vector, o_Vector_Valid); end
    i_nRst = 1;
    tick();
    vectors++; if (o_Vector_Valid !== 1'b0 || bus.o_Data !== 8'hE0) begin errors++; $display("FAIL post_rst got %b/%h exp 0/e0", o_Vector_Valid, bus.o_Data); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_if_edge();
    test_ei_delay();
    test_ack();
    test_ack_empty();
    test_write_edge();
    test_di_ei_reti();
    test_enable_low();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
